fifo_write_ctrl: RTL and testbench

- Write-side controller of the asynchronous FIFO, running in the write clock domain.
- Owns the write pointer (binary address plus Gray-coded pointer) and gates writes into the dual-port RAM.
- Brings the read-domain Gray read pointer across through a two-flop synchronizer and produces registered FULL, ALMOST_FULL and sticky OVERFLOW flags.
- Mirror of the read-side empty-flag logic.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_write_ctrl_if.sv | 27 ++
 rtl/fifo_write_ctrl_sync.sv | 26 ++
 rtl/fifo_write_ctrl.sv | 68 ++++++
 tb/tb_fifo_write_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and Gray/binary pointer helpers
package fifo_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_AF_MARGIN = 2;

  // 16-bit working width covers the full legal pointer range; callers zero-extend and truncate
  function automatic logic [15:0] bin2gray(input logic [15:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

  function automatic logic [15:0] gray2bin(input logic [15:0] i_gray);
    logic [15:0] w_bin;
    w_bin[15] = i_gray[15];
    for (int i = 14; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ i_gray[i];
    end
    return w_bin;
  endfunction

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// rtl/fifo_write_ctrl_if.sv - write-side FIFO controller signal bundle
interface fifo_write_ctrl_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             WRITE_ENA;
  logic [WIDTH-1:0] READ_PTR;
  logic [WIDTH-1:0] WRITE_PTR;
  logic [WIDTH-2:0] WRITE_ADDR;
  logic             MEM_WE;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             OVERFLOW;

  modport master (
    input  WRITE_ENA, READ_PTR,
    output WRITE_PTR, WRITE_ADDR, MEM_WE, FULL, ALMOST_FULL, OVERFLOW
  );

  modport slave (
    output WRITE_ENA, READ_PTR,
    input  WRITE_PTR, WRITE_ADDR, MEM_WE, FULL, ALMOST_FULL, OVERFLOW
  );

endinterface

// File: rtl/fifo_write_ctrl_sync.sv
// rtl/fifo_write_ctrl_sync.sv - two-flop synchronizer for a Gray-coded pointer
module fifo_write_ctrl_sync #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - async FIFO write-domain pointer, full/almost-full and overflow
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int AF_MARGIN = DEFAULT_AF_MARGIN
) (
  input  logic               CLK,
  input  logic               RST,
  fifo_write_ctrl_if.master  bus
);

  localparam int DEPTH = 1 << (WIDTH - 1);

  logic [WIDTH-1:0] r_wbin;
  logic [WIDTH-1:0] r_wgray;
  logic             r_full;
  logic             r_afull;
  logic             r_ovf;

  logic             w_accept;
  logic [WIDTH-1:0] w_wbin_next;
  logic [WIDTH-1:0] w_wgray_next;
  logic [WIDTH-1:0] w_rq2;
  logic [WIDTH-1:0] w_rbin_sync;
  logic [WIDTH-1:0] w_fill_next;
  logic [WIDTH-1:0] w_full_cmp;

  fifo_write_ctrl_sync #(.WIDTH(WIDTH)) u_rptr_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (bus.READ_PTR),
    .o_q   (w_rq2)
  );

  assign w_accept     = bus.WRITE_ENA & ~r_full;
  assign w_wbin_next  = r_wbin + WIDTH'(w_accept);
  assign w_wgray_next = WIDTH'(bin2gray(16'(w_wbin_next)));
  assign w_rbin_sync  = WIDTH'(gray2bin(16'(w_rq2)));
  assign w_fill_next  = w_wbin_next - w_rbin_sync;
  // Full means one lap ahead: the two MSBs of the Gray pointer differ, the rest match
  assign w_full_cmp   = {~w_rq2[WIDTH-1:WIDTH-2], w_rq2[WIDTH-3:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= (w_wgray_next == w_full_cmp);
      r_afull <= (w_fill_next >= WIDTH'(DEPTH - AF_MARGIN));
      r_ovf   <= r_ovf | (bus.WRITE_ENA & r_full);
    end
  end

  // RAM strobe is suppressed while reset is held so no stray write lands during reset
  assign bus.MEM_WE      = w_accept & ~RST;
  assign bus.WRITE_PTR   = r_wgray;
  assign bus.WRITE_ADDR  = r_wbin[WIDTH-2:0];
  assign bus.FULL        = r_full;
  assign bus.ALMOST_FULL = r_afull;
  assign bus.OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - directed scoreboard bench for fifo_write_ctrl (WIDTH=4)
module tb_fifo_write_ctrl;

  typedef struct packed {
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  int   m_wbin;
  int   m_rq1;
  int   m_rq2;
  logic m_full;
  logic m_af;
  logic m_ovf;

  fifo_write_ctrl_if #(.WIDTH(4)) bus ();

  fifo_write_ctrl #(.WIDTH(4), .AF_MARGIN(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_wbin = 0;
    m_rq1  = 0;
    m_rq2  = 0;
    m_full = 1'b0;
    m_af   = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".wptr"},  32'(bus.WRITE_PTR),   32'(0));
    chk({tag, ".waddr"}, 32'(bus.WRITE_ADDR),  32'(0));
    chk({tag, ".memwe"}, 32'(bus.MEM_WE),      32'(0));
    chk({tag, ".full"},  32'(bus.FULL),        32'(0));
    chk({tag, ".af"},    32'(bus.ALMOST_FULL), 32'(0));
    chk({tag, ".ovf"},   32'(bus.OVERFLOW),    32'(0));
  endtask

  // One write-clock cycle: drive, predict, then compare after the edge
  task automatic step(input logic we, input int rbin, input string tag);
    exp_t e;
    exp_t got;
    int   acc;
    int   wn;
    int   fill;
    @(negedge clk);
    bus.WRITE_ENA = we;
    bus.READ_PTR  = gray4(rbin);
    #1;
    acc = (we && !m_full) ? 1 : 0;
    chk({tag, ".memwe"}, 32'(bus.MEM_WE), 32'(acc));
    wn   = (m_wbin + acc) & 15;
    fill = (wn - m_rq2) & 15;
    e.wptr  = gray4(wn);
    e.waddr = 3'(wn & 7);
    e.full  = (fill == 8);
    e.af    = (fill >= 6);
    e.ovf   = m_ovf | (we & m_full);
    sb_q.push_back(e);
    m_wbin = wn;
    m_full = e.full;
    m_af   = e.af;
    m_ovf  = e.ovf;
    m_rq2  = m_rq1;
    m_rq1  = rbin & 15;
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".wptr"},  32'(bus.WRITE_PTR),   32'(got.wptr));
    chk({tag, ".waddr"}, 32'(bus.WRITE_ADDR),  32'(got.waddr));
    chk({tag, ".full"},  32'(bus.FULL),        32'(got.full));
    chk({tag, ".af"},    32'(bus.ALMOST_FULL), 32'(got.af));
    chk({tag, ".ovf"},   32'(bus.OVERFLOW),    32'(got.ovf));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();

    rst           = 1'b1;
    bus.WRITE_ENA = 1'b1;
    bus.READ_PTR  = 4'b0101;
    #1;
    check_all_zero("reset0");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end
    @(negedge clk);
    bus.WRITE_ENA = 1'b0;
    bus.READ_PTR  = 4'b0000;
    rst           = 1'b0;

    for (int i = 0; i < 8; i++) step(1'b1, 0, "fill");
    chk("fill.wptr_end", 32'(bus.WRITE_PTR), 32'(4'b1100));
    chk("fill.full_end", 32'(bus.FULL), 32'(1));

    for (int i = 0; i < 3; i++) step(1'b1, 0, "ovf");
    step(1'b0, 0, "ovf_idle");
    chk("ovf.sticky", 32'(bus.OVERFLOW), 32'(1));

    for (int i = 0; i < 3; i++) step(1'b0, 1, "release");
    chk("release.full_drop", 32'(bus.FULL), 32'(0));
    step(1'b1, 1, "refill");
    chk("refill.wptr", 32'(bus.WRITE_PTR), 32'(4'b1101));
    chk("refill.full", 32'(bus.FULL), 32'(1));

    for (int r = 2; r <= 7; r++) step(1'b0, r, "drain");
    for (int i = 0; i < 3; i++) step(1'b0, 7, "settle");
    for (int j = 1; j <= 16; j++) begin
      step(1'b1, 7 + j, "wrap");
      if (m_wbin == 8) begin
        chk("wrap.at1100_wptr", 32'(bus.WRITE_PTR), 32'(4'b1100));
        chk("wrap.at1100_full", 32'(bus.FULL), 32'(0));
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 24, "hold");
    for (int i = 0; i < 7; i++) step(1'b1, 24, "lap");
    chk("lap.wptr", 32'(bus.WRITE_PTR), 32'(4'b0000));
    chk("lap.full", 32'(bus.FULL), 32'(1));

    step(1'b1, 24, "pre_rst");
    chk("pre_rst.ovf", 32'(bus.OVERFLOW), 32'(1));
    @(negedge clk);
    #2;
    rst           = 1'b1;
    bus.WRITE_ENA = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    bus.WRITE_ENA = 1'b0;
    bus.READ_PTR  = 4'b0000;
    rst           = 1'b0;
    #1;
    chk("post_rst.waddr", 32'(bus.WRITE_ADDR), 32'(0));
    step(1'b1, 0, "post_rst");
    chk("post_rst.wptr", 32'(bus.WRITE_PTR), 32'(4'b0001));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
